// File: rtl/fifo_adapter_pkg.sv
// Shared constants and helper functions for the FIFO read-side stream adapter.
package fifo_adapter_pkg;

    localparam int DATA_WIDTH_DEF = 36;

    // Bits needed to index n items, never less than one.
    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

    function automatic int popcount(input logic [7:0] v);
        int c;
        c = 0;
        for (int i = 0; i < 8; i++) begin
            c += int'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// Circular skid buffer with separate head/tail pointers and an occupancy count.
module fifo_skid_buf
    import fifo_adapter_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              clear,
    input  logic                              push,
    input  logic [DATA_WIDTH-1:0]             push_data,
    input  logic                              pop,
    output logic [clog2_min1(DEPTH + 1)-1:0]  count,
    output logic [DATA_WIDTH-1:0]             head_data
);

    localparam int PTR_W = clog2_min1(DEPTH);
    localparam int CNT_W = clog2_min1(DEPTH + 1);

    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];

    // DEPTH need not be a power of two, so wrap explicitly.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        mem_d   = mem_q;
        if (clear) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                mem_d[tail_q] = push_data;
                tail_d        = ptr_inc(tail_q);
            end
            if (pop) begin
                head_d = ptr_inc(head_q);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end

    assign count     = count_q;
    assign head_data = mem_q[head_q];

    // The upstream credit check must make an overflowing push unreachable.
    assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && !clear && (count_q == CNT_W'(DEPTH))));

endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// Drives the FIFO read enable, absorbs the fixed read latency and presents a
// valid/ready stream from a credit-controlled skid buffer.
module fifo_rd_stream_adapter
    import fifo_adapter_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int RD_LATENCY = 1,
    parameter int BUF_DEPTH  = 2,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clock0,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    input  logic                  fifo_underrun,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_re,
    input  logic                  flush,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [CNT_WIDTH-1:0]  word_count,
    output logic                  underrun_err
);

    localparam int BCNT_W = clog2_min1(BUF_DEPTH + 1);
    localparam int OCC_W  = clog2_min1(BUF_DEPTH + RD_LATENCY + 1);

    if (RD_LATENCY < 1 || RD_LATENCY > 2) begin : g_bad_latency
        $error("fifo_rd_stream_adapter: RD_LATENCY must be 1 or 2");
    end
    if (BUF_DEPTH < RD_LATENCY + 1) begin : g_bad_depth
        $error("fifo_rd_stream_adapter: BUF_DEPTH must be at least RD_LATENCY+1");
    end

    logic [RD_LATENCY-1:0] pipe_q, pipe_d;
    logic [CNT_WIDTH-1:0]  word_count_q, word_count_d;
    logic                  underrun_err_q, underrun_err_d;
    logic [BCNT_W-1:0]     buf_cnt;
    logic [DATA_WIDTH-1:0] buf_head;
    logic [OCC_W-1:0]      occupancy;
    logic                  pop;
    logic                  capture;

    always_comb begin
        pop       = (buf_cnt != '0) && m_ready;
        occupancy = OCC_W'(buf_cnt) + OCC_W'(popcount(8'(pipe_q))) - OCC_W'(pop);
        // rst_n gates the read enable so the FIFO sees no read while held in reset.
        fifo_re   = rst_n && !fifo_empty && !flush && (occupancy < OCC_W'(BUF_DEPTH));

        pipe_d = '0;
        if (!flush) begin
            pipe_d[0] = fifo_re;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_d[i] = pipe_q[i-1];
            end
        end

        capture = pipe_q[RD_LATENCY-1] && !flush;

        word_count_d = word_count_q;
        if (pop && !flush) begin
            word_count_d = word_count_q + CNT_WIDTH'(1);
        end

        underrun_err_d = underrun_err_q | fifo_underrun;
    end

    always_ff @(posedge clock0 or negedge rst_n) begin
        if (!rst_n) begin
            pipe_q         <= '0;
            word_count_q   <= '0;
            underrun_err_q <= 1'b0;
        end else begin
            pipe_q         <= pipe_d;
            word_count_q   <= word_count_d;
            underrun_err_q <= underrun_err_d;
        end
    end

    fifo_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (BUF_DEPTH)
    ) u_skid_buf (
        .clk       (clock0),
        .rst_n     (rst_n),
        .clear     (flush),
        .push      (capture),
        .push_data (fifo_dout),
        .pop       (pop && !flush),
        .count     (buf_cnt),
        .head_data (buf_head)
    );

    assign m_valid      = (buf_cnt != '0);
    assign m_data       = buf_head;
    assign word_count   = word_count_q;
    assign underrun_err = underrun_err_q;

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Directed bench: behavioural FIFO source, in-order scoreboard and fixed checkpoints.
module tb_fifo_rd_stream_adapter;

    localparam int DW      = 36;
    // Depth 3 makes "two buffered plus one in flight" reachable for the flush case.
    localparam int DEPTH   = 3;
    localparam int NSTREAM = 1024;

    logic          clock0;
    logic          rst_n;
    logic          fifo_empty;
    logic          fifo_underrun;
    logic [DW-1:0] fifo_dout;
    logic          fifo_re;
    logic          flush;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic [31:0]   word_count;
    logic          underrun_err;

    int            checks    = 0;
    int            failures  = 0;
    int            delivered = 0;
    int            guard;
    int            base;
    int            remaining;
    logic [31:0]   wc0;
    logic [DW-1:0] held;
    logic [DW-1:0] last_del;
    logic [DW-1:0] fw [6];
    logic [DW-1:0] fq [$];
    logic [DW-1:0] sentq [$];

    fifo_rd_stream_adapter #(
        .DATA_WIDTH (DW),
        .RD_LATENCY (1),
        .BUF_DEPTH  (DEPTH),
        .CNT_WIDTH  (32)
    ) dut (
        .clock0        (clock0),
        .rst_n         (rst_n),
        .fifo_empty    (fifo_empty),
        .fifo_underrun (fifo_underrun),
        .fifo_dout     (fifo_dout),
        .fifo_re       (fifo_re),
        .flush         (flush),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .word_count    (word_count),
        .underrun_err  (underrun_err)
    );

    initial clock0 = 1'b0;
    always #5 clock0 = ~clock0;

    initial begin
        #500000;
        $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [DW-1:0] rand_word();
        return {4'($urandom), $urandom};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample at the falling edge, model the FIFO read just after the rising edge.
    task automatic tick();
        logic          s_re;
        logic          s_pop;
        logic          s_flush;
        logic [DW-1:0] s_data;
        logic [DW-1:0] e;
        @(negedge clock0);
        s_re    = fifo_re;
        s_flush = flush;
        s_pop   = m_valid && m_ready && !flush;
        s_data  = m_data;
        if (s_pop) begin
            chk("deliver_has_expected", 64'(sentq.size() != 0), 1);
            if (sentq.size() != 0) begin
                e = sentq.pop_front();
                chk("deliver_data", s_data, e);
            end
            delivered++;
            last_del = s_data;
        end
        if (s_re) chk("re_not_empty", 64'(fq.size() != 0), 1);
        @(posedge clock0);
        #1;
        if (s_flush) sentq.delete();
        if (s_re && fq.size() != 0) begin
            fifo_dout = fq.pop_front();
            sentq.push_back(fifo_dout);
        end
        fifo_empty = (fq.size() == 0);
        chk("outstanding_le_depth", 64'(sentq.size() <= DEPTH), 1);
    endtask

    initial begin
        rst_n         = 1'b0;
        fifo_empty    = 1'b0;
        fifo_underrun = 1'b0;
        fifo_dout     = '0;
        flush         = 1'b0;
        m_ready       = 1'b1;
        last_del      = '0;
        for (int i = 0; i < NSTREAM; i++) fq.push_back(rand_word());
        for (int i = 0; i < 6; i++) fw[i] = rand_word();

        // Reset held with a non-empty FIFO and a ready sink.
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rst_fifo_re", fifo_re, 0);
            chk("rst_m_valid", m_valid, 0);
            chk("rst_m_data", m_data, 0);
            chk("rst_word_count", word_count, 0);
            chk("rst_underrun_err", underrun_err, 0);
        end
        rst_n = 1'b1;
        #1;
        chk("re_after_reset", fifo_re, 1);

        // Streaming: valid two edges after the first read edge, then no gaps.
        tick();
        chk("latency_edge1_valid", m_valid, 0);
        tick();
        chk("latency_edge2_valid", m_valid, 1);
        guard = 0;
        while (delivered < NSTREAM / 2 && guard < 4000) begin
            chk("stream_no_gap", m_valid, 1);
            tick();
            guard++;
        end

        // Backpressure for 10 cycles.
        m_ready = 1'b0;
        #1;
        held = m_data;
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk("bp_valid", m_valid, 1);
            chk("bp_data_stable", m_data, held);
            if (i >= 2) chk("bp_re_low", fifo_re, 0);
        end
        m_ready = 1'b1;
        #1;
        chk("bp_re_resume", fifo_re, 1);
        guard = 0;
        while (delivered < NSTREAM && guard < 4000) begin
            chk("stream_no_gap", m_valid, 1);
            tick();
            guard++;
        end
        chk("stream_in_budget", 64'(guard < 4000), 1);
        chk("stream_end_valid", m_valid, 0);
        chk("stream_word_count", word_count, NSTREAM);

        // Empty source, then one word.
        for (int i = 0; i < 50; i++) begin
            tick();
            chk("empty_re", fifo_re, 0);
            chk("empty_valid", m_valid, 0);
        end
        base = delivered;
        fq.push_back(fw[0]);
        fifo_empty = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        chk("single_delivered", delivered - base, 1);
        chk("single_data", last_del, fw[0]);
        chk("single_word_count", word_count, NSTREAM + 1);
        chk("single_valid_after", m_valid, 0);

        // Flush with two buffered and one in flight; the fourth word survives.
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) fq.push_back(fw[i + 1]);
        fifo_empty = 1'b0;
        tick();
        tick();
        tick();
        chk("pre_flush_outstanding", sentq.size(), 3);
        chk("pre_flush_re", fifo_re, 0);
        chk("pre_flush_valid", m_valid, 1);
        wc0   = word_count;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_valid_next", m_valid, 0);
        chk("flush_word_count", word_count, wc0);
        base    = delivered;
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        chk("flush_next_count", delivered - base, 1);
        chk("flush_next_data", last_del, fw[4]);
        chk("flush_next_word_count", word_count, wc0 + 1);

        // Flush with a ready sink: blocks the read and suppresses the count.
        m_ready = 1'b0;
        fq.push_back(fw[5]);
        fifo_empty = 1'b0;
        tick();
        tick();
        tick();
        chk("flush2_pre_valid", m_valid, 1);
        fq.push_back(fw[2]);
        fifo_empty = 1'b0;
        m_ready    = 1'b1;
        flush      = 1'b1;
        #1;
        chk("flush_blocks_re", fifo_re, 0);
        wc0 = word_count;
        tick();
        flush = 1'b0;
        chk("flush_no_count", word_count, wc0);
        chk("flush2_valid_next", m_valid, 0);
        base = delivered;
        for (int i = 0; i < 8; i++) tick();
        chk("flush2_next_count", delivered - base, 1);
        chk("flush2_next_data", last_del, fw[2]);
        chk("flush2_word_count", word_count, wc0 + 1);

        // Underrun stickiness, then asynchronous reset mid-stream.
        for (int i = 0; i < 20; i++) fq.push_back(rand_word());
        fifo_empty = 1'b0;
        tick();
        tick();
        tick();
        fifo_underrun = 1'b1;
        tick();
        fifo_underrun = 1'b0;
        chk("underrun_set", underrun_err, 1);
        tick();
        tick();
        tick();
        chk("underrun_sticky", underrun_err, 1);
        chk("midstream_valid", m_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_fifo_re", fifo_re, 0);
        chk("async_rst_m_valid", m_valid, 0);
        chk("async_rst_m_data", m_data, 0);
        chk("async_rst_word_count", word_count, 0);
        chk("async_rst_underrun", underrun_err, 0);
        sentq.delete();
        tick();
        tick();
        chk("rst_hold_m_valid", m_valid, 0);
        chk("rst_hold_fifo_re", fifo_re, 0);
        rst_n     = 1'b1;
        remaining = fq.size();
        base      = delivered;
        guard     = 0;
        while ((fq.size() != 0 || sentq.size() != 0) && guard < 200) begin
            tick();
            guard++;
        end
        chk("restart_in_budget", 64'(guard < 200), 1);
        chk("restart_delivered", delivered - base, remaining);
        chk("restart_word_count", word_count, remaining);
        chk("restart_end_valid", m_valid, 0);
        chk("restart_underrun_clear", underrun_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
